// File: rtl/btb_pkg.sv
// Shared constants and field-geometry helpers for the set-associative branch target buffer.
package btb_pkg;

    localparam int PC_W_DEF        = 64;
    localparam int OFFSET_BITS_DEF = 2;
    localparam int INDEX_BITS_DEF  = 5;
    localparam int WAYS_DEF        = 2;
    localparam int CNT_W_DEF       = 2;

    localparam logic [CNT_W_DEF-1:0] CNT_MAX        = '1;
    localparam logic [CNT_W_DEF-1:0] CNT_WEAK_TAKEN = CNT_W_DEF'(1 << (CNT_W_DEF - 1));

    localparam int TAG_W   = PC_W_DEF - OFFSET_BITS_DEF - INDEX_BITS_DEF;
    localparam int ENTRY_W = 1 + 1 + TAG_W + PC_W_DEF + CNT_W_DEF;

    function automatic int tag_w(input int pc_w, input int offset_bits, input int index_bits);
        return pc_w - offset_bits - index_bits;
    endfunction

    function automatic int entry_w(input int pc_w, input int offset_bits, input int index_bits,
                                   input int cnt_w);
        return 2 + tag_w(pc_w, offset_bits, index_bits) + pc_w + cnt_w;
    endfunction

    function automatic int unsigned cnt_max(input int unsigned cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

    function automatic int unsigned cnt_weak_taken(input int unsigned cnt_w);
        return 32'd1 << (cnt_w - 1);
    endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// Combinational saturating up/down counter step with a force-to-max input.
module btb_sat_counter #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             inc,
    input  logic             dec,
    input  logic             set_max,
    output logic [CNT_W-1:0] cnt_next
);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        cnt_next = cnt;
        if (set_max) begin
            cnt_next = '1;
        end else if (inc && (cnt != '1)) begin
            cnt_next = cnt + CNT_W'(1);
        end else if (dec && (cnt != '0)) begin
            cnt_next = cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/btb_set_assoc.sv
// Set-associative BTB: tagged entries with 2-bit direction counters, per-set round-robin
// replacement, registered one-cycle lookup, read-before-write against same-cycle updates.
module btb_set_assoc
    import btb_pkg::*;
#(
    parameter int PC_W        = 64,
    parameter int OFFSET_BITS = 2,
    parameter int INDEX_BITS  = 5,
    parameter int WAYS        = 2,
    parameter int CNT_W       = 2
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            en,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_taken,
    input  logic            upd_jump,
    input  logic            flush
);

    localparam int SETS   = 1 << INDEX_BITS;
    localparam int TAG_LO = OFFSET_BITS + INDEX_BITS;
    localparam int TAG_W_P = tag_w(PC_W, OFFSET_BITS, INDEX_BITS);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(cnt_weak_taken(CNT_W));

    logic               valid_q  [SETS][WAYS];
    logic               jump_q   [SETS][WAYS];
    logic [TAG_W_P-1:0] tag_q    [SETS][WAYS];
    logic [PC_W-1:0]    target_q [SETS][WAYS];
    logic [CNT_W-1:0]   cnt_q    [SETS][WAYS];

    logic [INDEX_BITS-1:0] l_idx, u_idx;
    logic [TAG_W_P-1:0]    l_tag, u_tag;
    logic                  l_hit, l_taken;
    logic [WAY_W-1:0]      l_way;
    logic                  u_hit, u_free;
    logic [WAY_W-1:0]      u_way, u_free_way, victim_way, alloc_way;
    logic                  u_train, u_alloc, u_replace, u_wr_target;
    logic [CNT_W-1:0]      hit_cnt_next;
    logic                  unused_offset;

    assign l_idx = lookup_pc[TAG_LO-1:OFFSET_BITS];
    assign l_tag = lookup_pc[PC_W-1:TAG_LO];
    assign u_idx = upd_pc[TAG_LO-1:OFFSET_BITS];
    assign u_tag = upd_pc[PC_W-1:TAG_LO];
    assign unused_offset = ^{lookup_pc[OFFSET_BITS-1:0], upd_pc[OFFSET_BITS-1:0]};

    // Descending scan so the lowest matching way is the one left standing.
    always_comb begin
        l_hit = 1'b0;
        l_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[l_idx][w] && (tag_q[l_idx][w] == l_tag)) begin
                l_hit = 1'b1;
                l_way = WAY_W'(w);
            end
        end
    end

    assign l_taken = l_hit & (jump_q[l_idx][l_way] | cnt_q[l_idx][l_way][CNT_W-1]);

    always_comb begin
        u_hit      = 1'b0;
        u_way      = '0;
        u_free     = 1'b0;
        u_free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
                u_hit = 1'b1;
                u_way = WAY_W'(w);
            end
            if (!valid_q[u_idx][w]) begin
                u_free     = 1'b1;
                u_free_way = WAY_W'(w);
            end
        end
    end

    assign alloc_way   = u_free ? u_free_way : victim_way;
    assign u_train     = upd_valid & ~flush & u_hit;
    assign u_alloc     = upd_valid & ~flush & ~u_hit & (upd_taken | upd_jump);
    assign u_replace   = u_alloc & ~u_free;
    assign u_wr_target = (u_train & (upd_taken | upd_jump)) | u_alloc;

    btb_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .cnt      (cnt_q[u_idx][u_way]),
        .inc      (upd_taken),
        .dec      (~upd_taken & ~upd_jump),
        .set_max  (upd_jump),
        .cnt_next (hit_cnt_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pred_taken  <= 1'b0;
            pred_target <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    cnt_q[s][w]   <= '0;
                end
            end
        end else begin
            if (en) begin
                pred_taken  <= l_taken;
                pred_target <= l_taken ? target_q[l_idx][l_way] : '0;
            end
            if (flush) begin
                for (int s = 0; s < SETS; s++) begin
                    for (int w = 0; w < WAYS; w++) begin
                        valid_q[s][w] <= 1'b0;
                    end
                end
            end else if (u_train) begin
                cnt_q[u_idx][u_way] <= hit_cnt_next;
            end else if (u_alloc) begin
                valid_q[u_idx][alloc_way] <= 1'b1;
                cnt_q[u_idx][alloc_way]   <= upd_jump ? CNT_FULL : CNT_WEAK;
            end
        end
    end

    // NOTE: payload storage has no reset; it is only ever read behind a valid bit.
    always_ff @(posedge clk) begin
        if (u_wr_target) begin
            target_q[u_idx][u_hit ? u_way : alloc_way] <= upd_target;
        end
        if (u_train && upd_jump) begin
            jump_q[u_idx][u_way] <= 1'b1;
        end else if (u_alloc) begin
            jump_q[u_idx][alloc_way] <= upd_jump;
            tag_q[u_idx][alloc_way]  <= u_tag;
        end
    end

    generate
        if (WAYS > 1) begin : g_victim
            logic [WAY_W-1:0] victim_q [SETS];

            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    for (int s = 0; s < SETS; s++) begin
                        victim_q[s] <= '0;
                    end
                end else if (u_replace) begin
                    victim_q[u_idx] <= victim_q[u_idx] + WAY_W'(1);
                end
            end

            assign victim_way = victim_q[u_idx];
        end else begin : g_no_victim
            assign victim_way = '0;
        end
    endgenerate

endmodule
